// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry writeback holding buffer with an age bit relative to its sibling buffer.
// Latency: a handshake at edge N makes the entry visible on buf_valid after edge N.
// Backpressure: ready = !buf_valid || drain, forced low during flush; independent of in_valid.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   flush               discard the held entry at the edge
//   in_valid/ready      upstream handshake; in_req carries addr+data
//   drain               this buffer is granted this cycle
//   other_valid/drain   sibling buffer state, used to derive the age bit
//   buf_valid, buf_req  held entry
//   young               held entry arrived after the sibling's current entry
module wb_skid_buffer
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    in_valid,
  output logic    ready,
  input  wb_req_t in_req,
  input  logic    drain,
  input  logic    other_valid,
  input  logic    other_drain,
  output logic    buf_valid,
  output logic    young,
  output wb_req_t buf_req
);

  logic load;

  assign ready = !flush && (!buf_valid || drain);
  assign load  = in_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      young     <= 1'b0;
      buf_req   <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
      young     <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_req   <= in_req;
      // Younger only if the sibling's entry survives this edge; a sibling
      // reloading on the same edge yields two equal-age entries.
      young     <= other_valid && !other_drain;
    end else begin
      if (drain) begin
        buf_valid <= 1'b0;
      end
      // Once the older sibling entry leaves, this entry becomes the oldest.
      if (drain || other_drain) begin
        young <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port; tracks pending writes.
// Latency: handshake at edge N -> registered write presented after edge N+1; 1 write/cycle sustained.
// Backpressure: per-requester one-entry skid buffer; ready = buffer free or draining, low during flush.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   req0_* / req1_*               ALU / load writeback valid-ready channels (addr, data)
//   sb_set_en, sb_set_addr        issue stage marks a destination pending
//   flush                         discard buffered writes and pending bits
//   rf_write_en/dest/data         registered register-file write port
//   pending_mask                  bit i set while a write to register i is in flight
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic                sb_set_en,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  input  logic                flush,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_dest,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] pending_mask
);

  wb_req_t req0_in, req1_in, buf0_req, buf1_req, win;
  logic    buf0_valid, buf1_valid, young0, young1;
  logic    grant0, grant1, tie, fire;
  req_id_e rr_ptr;
  logic [NUM_REGS-1:0] pending_next;

  assign req0_in = '{addr: req0_addr, data: req0_data};
  assign req1_in = '{addr: req1_addr, data: req1_data};

  wb_skid_buffer u_buf0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(req0_valid), .ready(req0_ready), .in_req(req0_in),
    .drain(grant0), .other_valid(buf1_valid), .other_drain(grant1),
    .buf_valid(buf0_valid), .young(young0), .buf_req(buf0_req)
  );

  wb_skid_buffer u_buf1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(req1_valid), .ready(req1_ready), .in_req(req1_in),
    .drain(grant1), .other_valid(buf0_valid), .other_drain(grant0),
    .buf_valid(buf1_valid), .young(young1), .buf_req(buf1_req)
  );

  // Oldest first; equal ages fall back to the round-robin pointer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    tie    = 1'b0;
    if (buf0_valid && buf1_valid) begin
      if (young1) begin
        grant0 = 1'b1;
      end else if (young0) begin
        grant1 = 1'b1;
      end else begin
        tie = 1'b1;
        if (rr_ptr == REQ_ALU) grant0 = 1'b1;
        else                   grant1 = 1'b1;
      end
    end else begin
      grant0 = buf0_valid;
      grant1 = buf1_valid;
    end
  end

  // A flush suppresses the grant: buffers are emptied instead of written.
  assign fire = (grant0 || grant1) && !flush;
  assign win  = grant1 ? buf1_req : buf0_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= REQ_ALU;
    end else if (fire && tie) begin
      rr_ptr <= (rr_ptr == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_en   <= 1'b0;
      rf_write_dest <= '0;
      rf_write_data <= '0;
    end else if (fire) begin
      rf_write_dest <= win.addr;
      rf_write_data <= win.data;
      // Register 0 is hardwired; its slot is consumed without a write.
      rf_write_en   <= (win.addr != ZERO_REG);
    end else begin
      rf_write_en   <= 1'b0;
    end
  end

  // Clear before set so a same-edge re-issue keeps the bit for the newer writer.
  always_comb begin
    pending_next = pending_mask;
    if (fire) begin
      pending_next[win.addr] = 1'b0;
    end
    if (sb_set_en && (sb_set_addr != ZERO_REG)) begin
      pending_next[sb_set_addr] = 1'b1;
    end
    if (flush) begin
      pending_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= pending_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: expected writes are queued in acceptance order and a negedge monitor compares.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req0_valid = 1'b0, req1_valid = 1'b0;
  logic                req0_ready, req1_ready;
  logic [ADDR_W-1:0]   req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0]   req0_data = '0, req1_data = '0;
  logic                sb_set_en = 1'b0;
  logic [ADDR_W-1:0]   sb_set_addr = '0;
  logic                flush = 1'b0;
  logic                rf_write_en;
  logic [ADDR_W-1:0]   rf_write_dest;
  logic [DATA_W-1:0]   rf_write_data;
  logic [NUM_REGS-1:0] pending_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush),
    .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest), .rf_write_data(rf_write_data),
    .pending_mask(pending_mask)
  );

  typedef struct packed {
    logic              set_en;
    logic [ADDR_W-1:0] set_addr;
    logic              fl;
  } edge_t;

  int                  n_checks = 0;
  int                  n_pass   = 0;
  wb_req_t             exp_q[$];   // accepted, nonzero-destination writes in required write order
  edge_t               edge_q[$];  // per-edge scoreboard/flush inputs, consumed by the monitor
  logic [NUM_REGS-1:0] mask_m   = '0;
  logic                rr_m     = 1'b0; // 0: ALU wins the next same-edge pair
  logic                tie_pend = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: runs after each edge, pops expected writes and tracks the pending-mask model.
  always @(negedge clk) begin : monitor
    edge_t   r;
    wb_req_t e;
    if (rst && edge_q.size() > 0) begin
      r = edge_q.pop_front();
      if (r.fl) begin
        check("flush_no_write", {31'b0, rf_write_en}, 32'd0);
        mask_m = '0;
      end else begin
        if (rf_write_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write_en", {31'b0, rf_write_en}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_dest", {28'b0, rf_write_dest}, {28'b0, e.addr});
            check("wr_data", {8'b0, rf_write_data}, {8'b0, e.data});
            mask_m[e.addr] = 1'b0;
          end
        end
        if (r.set_en && r.set_addr != 0) mask_m[r.set_addr] = 1'b1;
      end
      check("pending_mask", {16'b0, pending_mask}, {16'b0, mask_m});
    end
  end

  // Reference model update for the edge about to happen (called between negedge and posedge).
  task automatic record();
    logic    h0, h1;
    wb_req_t e0, e1;
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    e0 = '{addr: req0_addr, data: req0_data};
    e1 = '{addr: req1_addr, data: req1_data};
    // A same-edge pair is resolved one edge later; a flush on that edge cancels it.
    if (tie_pend && !flush) rr_m = ~rr_m;
    tie_pend = 1'b0;
    if (flush) begin
      check("ready0_flush", {31'b0, req0_ready}, 32'd0);
      check("ready1_flush", {31'b0, req1_ready}, 32'd0);
      exp_q.delete();
    end
    if (h0 && h1) begin
      tie_pend = 1'b1;
      if (!rr_m) begin
        if (e0.addr != 0) exp_q.push_back(e0);
        if (e1.addr != 0) exp_q.push_back(e1);
      end else begin
        if (e1.addr != 0) exp_q.push_back(e1);
        if (e0.addr != 0) exp_q.push_back(e0);
      end
    end else if (h0) begin
      if (e0.addr != 0) exp_q.push_back(e0);
    end else if (h1) begin
      if (e1.addr != 0) exp_q.push_back(e1);
    end
    edge_q.push_back('{set_en: sb_set_en, set_addr: sb_set_addr, fl: flush});
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [23:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [23:0] d1,
                       input logic sb, input logic [3:0] sba, input logic fl);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    sb_set_en = sb; sb_set_addr = sba; flush = fl;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    @(negedge clk); #1;
    record();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic v0, input logic [3:0] a0, input logic [23:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [23:0] d1,
                      input logic sb, input logic [3:0] sba, input logic fl);
    drive(v0, a0, d0, v1, a1, d1, sb, sba, fl);
    cycle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    #2;
    check("rst_en",    {31'b0, rf_write_en}, 32'd0);
    check("rst_dest",  {28'b0, rf_write_dest}, 32'd0);
    check("rst_data",  {8'b0, rf_write_data}, 32'd0);
    check("rst_mask",  {16'b0, pending_mask}, 32'd0);
    check("rst_rdy0",  {31'b0, req0_ready}, 32'd1);
    check("rst_rdy1",  {31'b0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU alone with latency check.
    step(0, 0, 0, 0, 0, 0, 1, 4'd3, 0);
    check("sb_set3", {31'b0, pending_mask[3]}, 32'd1);
    step(1, 4'd3, 24'h12345, 0, 0, 0, 0, 0, 0);
    check("alu_not_yet", {31'b0, rf_write_en}, 32'd0);
    idle();
    check("alu_en",   {31'b0, rf_write_en}, 32'd1);
    check("alu_dest", {28'b0, rf_write_dest}, 32'd3);
    check("alu_data", {8'b0, rf_write_data}, 32'h12345);
    check("alu_clr3", {31'b0, pending_mask[3]}, 32'd0);

    // Same-edge ties alternate.
    step(1, 4'd4, 24'hAAAAA, 1, 4'd5, 24'h55555, 0, 0, 0);
    idle(); check("tie1_first",  {28'b0, rf_write_dest}, 32'd4);
    idle(); check("tie1_second", {28'b0, rf_write_dest}, 32'd5);
    step(1, 4'd4, 24'hAAAAA, 1, 4'd5, 24'h55555, 0, 0, 0);
    idle(); check("tie2_first",  {28'b0, rf_write_dest}, 32'd5);
    idle(); check("tie2_second", {28'b0, rf_write_dest}, 32'd4);

    // Same-address ordering.
    step(0, 0, 0, 1, 4'd6, 24'h00001, 0, 0, 0);
    step(1, 4'd6, 24'h00002, 0, 0, 0, 0, 0, 0);
    check("ord_first", {8'b0, rf_write_data}, 32'h00001);
    idle();
    check("ord_final", {8'b0, rf_write_data}, 32'h00002);

    // Register 0.
    step(1, 4'd0, 24'hFFFFF, 0, 0, 0, 0, 0, 0);
    idle();
    check("zero_no_en", {31'b0, rf_write_en}, 32'd0);
    check("zero_rdy0",  {31'b0, req0_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 4'd0, 0);
    check("zero_mask", {16'b0, pending_mask}, 32'd0);

    // Set and clear of register 7 on the same edge.
    step(0, 0, 0, 0, 0, 0, 1, 4'd7, 0);
    step(1, 4'd7, 24'h00777, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd7, 0);
    check("coll_en",   {31'b0, rf_write_en}, 32'd1);
    check("coll_bit7", {31'b0, pending_mask[7]}, 32'd1);

    // Flush with both buffers full.
    step(1, 4'd8, 24'h08888, 1, 4'd9, 24'h09999, 1, 4'd9, 0);
    drive(1, 4'd11, 24'h0BBBB, 1, 4'd12, 24'h0CCCC, 1, 4'd10, 1);
    #1;
    check("flush_rdy0", {31'b0, req0_ready}, 32'd0);
    check("flush_rdy1", {31'b0, req1_ready}, 32'd0);
    cycle();
    check("flush_en",   {31'b0, rf_write_en}, 32'd0);
    check("flush_mask", {16'b0, pending_mask}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_flush_rdy0", {31'b0, req0_ready}, 32'd1);
    check("post_flush_rdy1", {31'b0, req1_ready}, 32'd1);
    cycle();
    check("post_flush_en", {31'b0, rf_write_en}, 32'd0);

    // Reset mid-stream.
    step(1, 4'd13, 24'h0DDDD, 1, 4'd14, 24'h0EEEE, 1, 4'd13, 0);
    rst = 1'b0;
    #1;
    check("arst_en",   {31'b0, rf_write_en}, 32'd0);
    check("arst_dest", {28'b0, rf_write_dest}, 32'd0);
    check("arst_data", {8'b0, rf_write_data}, 32'd0);
    check("arst_mask", {16'b0, pending_mask}, 32'd0);
    exp_q.delete(); edge_q.delete();
    mask_m = '0; rr_m = 1'b0; tie_pend = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_en", {31'b0, rf_write_en}, 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 24'($urandom),
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 24'($urandom),
           $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 8; i++) idle();
    check("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 = ALU writeback, req1 = load writeback.
- Each requester has a one-entry skid buffer; grants are oldest-first with a round-robin tie-break.
- Drives registered write enable, destination and data straight into the register file.
- Keeps a 16-bit pending-write scoreboard that the issue stage uses for RAW hazard checks.

Parameters:
- DATA_W, 24, width of register data.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, register count; bit width of pending_mask.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  ALU request accepted this cycle when high together with req0_valid.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req1_valid  in  1  load writeback request.
- req1_ready  out  1  load request accepted this cycle when high together with req1_valid.
- req1_addr  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- sb_set_en  in  1  issue stage marks a destination as pending.
- sb_set_addr  in  ADDR_W  destination being marked.
- flush  in  1  synchronous discard of all buffered writes and pending bits.
- rf_write_en  out  1  register-file write enable.
- rf_write_dest  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- pending_mask  out  NUM_REGS  bit i = write to register i is in flight.

Behaviour:
- Reset (rst low, asynchronous):
  - Both buffers empty; rf_write_en, rf_write_dest, rf_write_data = 0.
  - pending_mask = 0; round-robin pointer = req0; age bits cleared.
- Skid buffer, per requester:
  - reqN_ready = !bufN_valid || grantN. Ready never depends on reqN_valid.
  - A handshake loads the buffer at the clock edge.
  - If the same edge also drains it by grant, the buffer reloads with the new entry.
- Age tracking:
  - An entry loaded while the other buffer already holds an entry is marked younger.
  - Entries loaded on the same edge are equal age.
- Arbitration, combinational on buffer state:
  - Only one buffer valid: grant it.
  - Both valid, different ages: grant the older.
  - Both valid, equal age: grant the requester at the round-robin pointer; the pointer then toggles to the other requester.
  - Result: every same-address pair is written in acceptance order, and no requester waits more than 1 grant.
- Output register:
  - On the grant edge, rf_write_dest and rf_write_data load from the granted buffer.
  - rf_write_en = 1 for one cycle, unless the destination is 0; then rf_write_en = 0 and the slot is consumed silently.
  - With no grant, rf_write_en = 0 and dest/data hold their last values.
- Latency and throughput:
  - Handshake at edge N, alone: write presented in the cycle after edge N+1; register file updates at edge N+2.
  - Sustained throughput is 1 write/cycle total.
- Scoreboard:
  - sb_set_en sets pending_mask[sb_set_addr] at the edge; addr 0 is ignored.
  - The bit clears on the edge where the output register loads that address, whether or not it is register 0.
  - Set and clear of the same address on the same edge: set wins (a newer in-flight writer exists).
  - Clear of an address that is not pending: no effect.
- flush, sampled at the edge:
  - Empties both buffers and forces rf_write_en = 0 on the next cycle.
  - Clears pending_mask; flush beats a simultaneous sb_set_en.
  - reqN_ready = 0 while flush is high, so no handshake occurs.
  - A write already presented in the current cycle still completes in the register file.
- Reset mid-operation: buffered entries are lost; no write is emitted after rst rises.

Decomposition:
- Package regfile_pkg:
  - Constants DATA_W = 24, ADDR_W = 4, NUM_REGS = 16, ZERO_REG = 0.
  - typedef wb_req_t: struct of addr and data.
  - typedef req_id_e {REQ_ALU, REQ_LOAD}.
- Sub-module wb_skid_buffer, instantiated twice: one-entry buffer with valid/ready, age bit and drain input.
- Arbiter, output register and scoreboard stay in the top module.

Test Plan:
- ALU alone: req0 addr 3, data 24'h12345 accepted at edge 1 -> rf_write_en = 1, dest 3, data 24'h12345 in the cycle after edge 2; pending[3] set earlier is 0 after edge 2.
- Same-edge tie: req0 addr 4 / 24'hAAAAA and req1 addr 5 / 24'h55555 accepted together after reset -> req0 written first, req1 the next cycle; repeat the tie -> req1 first.
- Ordering: req1 addr 6 / 24'h00001 accepted one edge before req0 addr 6 / 24'h00002 -> 24'h00001 then 24'h00002 written, final value 24'h00002.
- Zero register: req0 addr 0 / 24'hFFFFF -> slot consumed, rf_write_en stays 0, req0_ready recovers; sb_set_en with addr 0 leaves pending_mask = 0.
- Scoreboard collision: pending[7] set; write to 7 clears it on the same edge sb_set_en addr 7 arrives -> pending[7] remains 1.
- Flush and reset: both buffers full, flush high 1 cycle -> no further writes, pending_mask = 0, readies high afterwards; rst low mid-stream -> all outputs 0 immediately.
